// File: rtl/fc_event_collector.sv
// Event collector: sticky per-source pending bits, round-robin arbiter and output FIFO.
// Optional saturating lost-event counter enabled by defining FC_EVT_OVERFLOW_CNT_EN.
`default_nettype none

module fc_event_collector #(
  parameter int NB_SOURCES     = 16,
  parameter int EVENT_ID_WIDTH = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int ID_BASE        = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NB_SOURCES-1:0]     evt_i,
  output logic                      event_fifo_valid_o,
  output logic [EVENT_ID_WIDTH-1:0] event_fifo_data_o,
  input  logic                      event_fifo_fulln_i,
  output logic [NB_SOURCES-1:0]     pending_o,
  output logic                      overflow_o,
  input  logic                      clr_overflow_i,
  output logic [15:0]               overflow_cnt_o
);

  localparam int SRC_W = $clog2(NB_SOURCES);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [NB_SOURCES-1:0]     pending_reg;
  logic [SRC_W-1:0]          rr_ptr_reg;
  logic [PTR_W-1:0]          wr_ptr_reg;
  logic [PTR_W-1:0]          rd_ptr_reg;
  logic [CNT_W-1:0]          count_reg;
  logic                      overflow_reg;
  logic [EVENT_ID_WIDTH-1:0] mem [FIFO_DEPTH];

  logic                      pop;
  logic                      push_ok;
  logic                      grant_valid;
  logic [SRC_W-1:0]          grant_idx;
  logic [SRC_W:0]            scan_idx;
  logic [NB_SOURCES-1:0]     grant_vec;
  logic [NB_SOURCES-1:0]     lost_vec;
  logic [EVENT_ID_WIDTH-1:0] grant_id;
  logic [SRC_W-1:0]          rr_ptr_next;
  logic [CNT_W-1:0]          count_next;

  assign pop     = (count_reg != '0) & event_fifo_fulln_i;
  assign push_ok = (count_reg < CNT_W'(FIFO_DEPTH)) | pop;

  // First pending source at or after rr_ptr, wrapping at NB_SOURCES.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    grant_vec   = '0;
    for (int i = 0; i < NB_SOURCES; i++) begin
      scan_idx = {1'b0, rr_ptr_reg} + (SRC_W+1)'(i);
      if (scan_idx >= (SRC_W+1)'(NB_SOURCES))
        scan_idx = scan_idx - (SRC_W+1)'(NB_SOURCES);
      if (!grant_valid && push_ok && pending_reg[scan_idx[SRC_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx[SRC_W-1:0];
      end
    end
    if (grant_valid)
      grant_vec[grant_idx] = 1'b1;
  end

  assign lost_vec    = evt_i & pending_reg & ~grant_vec;
  assign grant_id    = EVENT_ID_WIDTH'(ID_BASE + int'(grant_idx));
  assign rr_ptr_next = !grant_valid ? rr_ptr_reg :
                       (grant_idx == SRC_W'(NB_SOURCES-1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    count_next = count_reg;
    case ({grant_valid, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_reg  <= '0;
      rr_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      pending_reg <= (pending_reg & ~grant_vec) | evt_i;
      rr_ptr_reg  <= rr_ptr_next;
      count_reg   <= count_next;
      if (grant_valid) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)         rd_ptr_reg <= rd_ptr_reg + 1'b1;
      // A new loss takes priority over a clear in the same cycle.
      if (lost_vec != '0)      overflow_reg <= 1'b1;
      else if (clr_overflow_i) overflow_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (grant_valid)
      mem[wr_ptr_reg] <= grant_id;
  end

`ifdef FC_EVT_OVERFLOW_CNT_EN
  logic [SRC_W:0] lost_pop;
  logic [15:0]    cnt_base;
  logic [16:0]    cnt_sum;
  logic [15:0]    overflow_cnt_reg;

  always_comb begin
    lost_pop = '0;
    for (int i = 0; i < NB_SOURCES; i++)
      lost_pop = lost_pop + (SRC_W+1)'(lost_vec[i]);
  end

  assign cnt_base = clr_overflow_i ? 16'h0 : overflow_cnt_reg;
  assign cnt_sum  = {1'b0, cnt_base} + 17'(lost_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      overflow_cnt_reg <= '0;
    else
      overflow_cnt_reg <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  assign overflow_cnt_o = overflow_cnt_reg;
`else
  assign overflow_cnt_o = 16'h0;
`endif

  assign event_fifo_valid_o = (count_reg != '0);
  assign event_fifo_data_o  = event_fifo_valid_o ? mem[rd_ptr_reg] : '0;
  assign pending_o          = pending_reg;
  assign overflow_o         = overflow_reg;

endmodule

`default_nettype wire
